// File: rtl/csr_port_arbiter.sv
// csr_port_arbiter: shares the single CSR array port between the execution
// stage (priority owner) and the debug monitor (latched single request).
//
// Build option: define CSR_ARB_STARVE_GUARD_EN to add the starvation guard
// (wait counter + FORCE state). Without it the monitor waits for a free
// execution-stage cycle indefinitely and ex_stall is tied low.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no monitor request; execution stage owns the port
// PEND  | monitor request latched; granted on first ex-free cycle
// FORCE | guard expired; ex stalled, monitor granted (guard build only)
// RESP  | mon_ack pulse; read data held in mon_rdata
module csr_port_arbiter #(
  parameter int unsigned MON_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_csr_req,
  input  logic        ex_csr_we,
  input  logic [11:0] ex_csr_adr,
  input  logic [31:0] ex_csr_wdata,
  output logic        ex_stall,
  input  logic        mon_req,
  input  logic        mon_we,
  input  logic [11:0] mon_adr,
  input  logic [31:0] mon_wdata,
  output logic        mon_busy,
  output logic        mon_ack,
  output logic [31:0] mon_rdata,
  output logic        csr_en,
  output logic        csr_we,
  output logic [11:0] csr_adr,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata
);

  if ((MON_WAIT_MAX < 1) || (MON_WAIT_MAX > ((1 << CNT_W) - 1))) begin : g_param_chk
    $error("csr_port_arbiter: MON_WAIT_MAX must be within 1..2^CNT_W-1");
  end

`ifdef CSR_ARB_STARVE_GUARD_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FORCE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WAIT_MAX  = CNT_W'(MON_WAIT_MAX);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MON_WAIT_MAX - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             ex_stall_q;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_RESP = 2'd3
  } state_t;
`endif

  state_t      state_q;
  logic        req_we_q;
  logic [11:0] req_adr_q;
  logic [31:0] req_wdata_q;
  logic [31:0] mon_rdata_q;
  logic        mon_ack_q;
  logic        mon_busy_q;
  logic        mon_grant;

  // Monitor owns the port when PEND finds the ex stage idle, or in FORCE.
  always_comb begin
    mon_grant = 1'b0;
    if (state_q == ST_PEND && !ex_csr_req) begin
      mon_grant = 1'b1;
    end
`ifdef CSR_ARB_STARVE_GUARD_EN
    if (state_q == ST_FORCE) begin
      mon_grant = 1'b1;
    end
`endif
  end

  // Port mux: latched monitor request on a monitor grant, else the ex stage.
  always_comb begin
    if (mon_grant) begin
      csr_en    = 1'b1;
      csr_we    = req_we_q;
      csr_adr   = req_adr_q;
      csr_wdata = req_wdata_q;
    end else begin
      csr_en    = ex_csr_req;
      csr_we    = ex_csr_we;
      csr_adr   = ex_csr_adr;
      csr_wdata = ex_csr_wdata;
    end
  end

  // Arbitration FSM with registered status outputs and request latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_we_q    <= 1'b0;
      req_adr_q   <= '0;
      req_wdata_q <= '0;
      mon_rdata_q <= '0;
      mon_ack_q   <= 1'b0;
      mon_busy_q  <= 1'b0;
`ifdef CSR_ARB_STARVE_GUARD_EN
      cnt_q       <= '0;
      ex_stall_q  <= 1'b0;
`endif
    end else begin
      mon_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mon_req) begin
            req_we_q    <= mon_we;
            req_adr_q   <= mon_adr;
            req_wdata_q <= mon_wdata;
            mon_busy_q  <= 1'b1;
            state_q     <= ST_PEND;
`ifdef CSR_ARB_STARVE_GUARD_EN
            cnt_q       <= '0;
`endif
          end
        end
        ST_PEND: begin
          if (!ex_csr_req) begin
            // Write requests also capture the pre-write contents.
            mon_rdata_q <= csr_rdata;
            mon_ack_q   <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
`ifdef CSR_ARB_STARVE_GUARD_EN
            if (cnt_q != WAIT_MAX) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
            if (cnt_q == WAIT_LAST) begin
              ex_stall_q <= 1'b1;
              state_q    <= ST_FORCE;
            end
`endif
          end
        end
`ifdef CSR_ARB_STARVE_GUARD_EN
        ST_FORCE: begin
          mon_rdata_q <= csr_rdata;
          mon_ack_q   <= 1'b1;
          ex_stall_q  <= 1'b0;
          state_q     <= ST_RESP;
        end
`endif
        ST_RESP: begin
          mon_busy_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          mon_busy_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign mon_ack   = mon_ack_q;
  assign mon_busy  = mon_busy_q;
  assign mon_rdata = mon_rdata_q;
`ifdef CSR_ARB_STARVE_GUARD_EN
  assign ex_stall  = ex_stall_q;
`else
  assign ex_stall  = 1'b0;
`endif

endmodule

// File: tb/tb_csr_port_arbiter.sv
// Directed bench for csr_port_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
module tb_csr_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_csr_req = 1'b0;
  logic        ex_csr_we = 1'b0;
  logic [11:0] ex_csr_adr = '0;
  logic [31:0] ex_csr_wdata = '0;
  logic        ex_stall;
  logic        mon_req = 1'b0;
  logic        mon_we = 1'b0;
  logic [11:0] mon_adr = '0;
  logic [31:0] mon_wdata = '0;
  logic        mon_busy;
  logic        mon_ack;
  logic [31:0] mon_rdata;
  logic        csr_en;
  logic        csr_we;
  logic [11:0] csr_adr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Fixed CSR array contents seen through the combinational read port.
  assign csr_rdata = (csr_adr == 12'h300) ? 32'h0000_1888 :
                     (csr_adr == 12'h305) ? 32'h0000_0055 : {20'h0, csr_adr};

  csr_port_arbiter #(.MON_WAIT_MAX(15), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_csr_req(ex_csr_req), .ex_csr_we(ex_csr_we), .ex_csr_adr(ex_csr_adr),
    .ex_csr_wdata(ex_csr_wdata), .ex_stall(ex_stall),
    .mon_req(mon_req), .mon_we(mon_we), .mon_adr(mon_adr), .mon_wdata(mon_wdata),
    .mon_busy(mon_busy), .mon_ack(mon_ack), .mon_rdata(mon_rdata),
    .csr_en(csr_en), .csr_we(csr_we), .csr_adr(csr_adr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ex_csr_req = 1'b1; ex_csr_adr = 12'h123; ex_csr_we = 1'b1; ex_csr_wdata = 32'hCAFE_0001;
    mon_req = 1'b1; mon_adr = 12'h300;
    @(negedge clk);
    n_cmp++; if (csr_en !== 1'b1) begin n_fail++; $display("FAIL rst_csr_en: got %b want 1", csr_en); end
    n_cmp++; if (csr_adr !== 12'h123) begin n_fail++; $display("FAIL rst_csr_adr: got %h want 123", csr_adr); end
    n_cmp++; if (csr_wdata !== 32'hCAFE_0001) begin n_fail++; $display("FAIL rst_csr_wdata: got %h want cafe0001", csr_wdata); end
    n_cmp++; if (mon_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mon_busy: got %b want 0", mon_busy); end
    n_cmp++; if (mon_ack !== 1'b0) begin n_fail++; $display("FAIL rst_mon_ack: got %b want 0", mon_ack); end
    n_cmp++; if (ex_stall !== 1'b0) begin n_fail++; $display("FAIL rst_ex_stall: got %b want 0", ex_stall); end
    n_cmp++; if (mon_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_mon_rdata: got %h want 0", mon_rdata); end
    ex_csr_req = 1'b0; mon_req = 1'b0;
    #1;
    n_cmp++; if (csr_en !== 1'b0) begin n_fail++; $display("FAIL rst_csr_en_idle: got %b want 0", csr_en); end
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_mon_read();
    mon_req = 1'b1; mon_we = 1'b0; mon_adr = 12'h300; ex_csr_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (csr_en !== 1'b0) begin n_fail++; $display("FAIL rd_c0_csr_en: got %b want 0", csr_en); end
    next_cycle();
    mon_req = 1'b0;
    @(negedge clk);
    n_cmp++; if ({csr_en, csr_we, csr_adr} !== {1'b1, 1'b0, 12'h300}) begin n_fail++; $display("FAIL rd_c1_grant: got en=%b we=%b adr=%h want 1 0 300", csr_en, csr_we, csr_adr); end
    n_cmp++; if ({mon_busy, mon_ack, ex_stall} !== 3'b100) begin n_fail++; $display("FAIL rd_c1_status: got busy/ack/stall=%b want 100", {mon_busy, mon_ack, ex_stall}); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (mon_ack !== 1'b1) begin n_fail++; $display("FAIL rd_c2_ack: got %b want 1", mon_ack); end
    n_cmp++; if (mon_rdata !== 32'h0000_1888) begin n_fail++; $display("FAIL rd_c2_rdata: got %h want 00001888", mon_rdata); end
    n_cmp++; if ({csr_en, ex_stall, mon_busy} !== 3'b001) begin n_fail++; $display("FAIL rd_c2_port: got en/stall/busy=%b want 001", {csr_en, ex_stall, mon_busy}); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if ({mon_ack, mon_busy} !== 2'b00) begin n_fail++; $display("FAIL rd_c3_done: got ack/busy=%b want 00", {mon_ack, mon_busy}); end
    n_cmp++; if (mon_rdata !== 32'h0000_1888) begin n_fail++; $display("FAIL rd_c3_hold: got %h want 00001888", mon_rdata); end
    next_cycle();
  endtask

  task automatic test_mon_write_ex_pulse();
    mon_req = 1'b1; mon_we = 1'b1; mon_adr = 12'h305; mon_wdata = 32'h0000_0100; ex_csr_req = 1'b0;
    @(negedge clk);
    next_cycle();
    mon_req = 1'b0;
    ex_csr_req = 1'b1; ex_csr_we = 1'b1; ex_csr_adr = 12'h340; ex_csr_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++; if ({csr_en, csr_we, csr_adr} !== {1'b1, 1'b1, 12'h340}) begin n_fail++; $display("FAIL wr_c1_ex_grant: got en=%b we=%b adr=%h want 1 1 340", csr_en, csr_we, csr_adr); end
    n_cmp++; if (csr_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_c1_ex_wdata: got %h want deadbeef", csr_wdata); end
    next_cycle();
    ex_csr_req = 1'b0; ex_csr_we = 1'b0;
    @(negedge clk);
    n_cmp++; if ({csr_en, csr_we, csr_adr} !== {1'b1, 1'b1, 12'h305}) begin n_fail++; $display("FAIL wr_c2_mon_grant: got en=%b we=%b adr=%h want 1 1 305", csr_en, csr_we, csr_adr); end
    n_cmp++; if (csr_wdata !== 32'h0000_0100) begin n_fail++; $display("FAIL wr_c2_wdata: got %h want 00000100", csr_wdata); end
    n_cmp++; if (mon_ack !== 1'b0) begin n_fail++; $display("FAIL wr_c2_ack: got %b want 0", mon_ack); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (mon_ack !== 1'b1) begin n_fail++; $display("FAIL wr_c3_ack: got %b want 1", mon_ack); end
    n_cmp++; if (mon_rdata !== 32'h0000_0055) begin n_fail++; $display("FAIL wr_c3_old_data: got %h want 00000055", mon_rdata); end
    next_cycle();
  endtask

  task automatic test_starve();
    int ex_grants = 0;
    int stalls = 0;
    int acks = 0;
    mon_req = 1'b1; mon_we = 1'b0; mon_adr = 12'h300;
    ex_csr_req = 1'b1; ex_csr_we = 1'b0; ex_csr_adr = 12'h341;
    @(negedge clk);
    n_cmp++; if ({csr_en, csr_adr} !== {1'b1, 12'h341}) begin n_fail++; $display("FAIL st_c0_ex: got en=%b adr=%h want 1 341", csr_en, csr_adr); end
    next_cycle();
    mon_req = 1'b0;
`ifdef CSR_ARB_STARVE_GUARD_EN
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (csr_en && csr_adr == 12'h341) ex_grants++;
      if (ex_stall) stalls++;
      if (mon_ack) acks++;
      next_cycle();
    end
    n_cmp++; if (ex_grants !== 15) begin n_fail++; $display("FAIL st_ex_grants: got %0d want 15", ex_grants); end
    n_cmp++; if ((stalls + acks) !== 0) begin n_fail++; $display("FAIL st_early_stall_ack: got %0d want 0", stalls + acks); end
    @(negedge clk);
    n_cmp++; if (ex_stall !== 1'b1) begin n_fail++; $display("FAIL st_c16_stall: got %b want 1", ex_stall); end
    n_cmp++; if ({csr_en, csr_adr} !== {1'b1, 12'h300}) begin n_fail++; $display("FAIL st_c16_force: got en=%b adr=%h want 1 300", csr_en, csr_adr); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if ({mon_ack, ex_stall} !== 2'b10) begin n_fail++; $display("FAIL st_c17_ack: got ack/stall=%b want 10", {mon_ack, ex_stall}); end
    n_cmp++; if ({csr_en, csr_adr} !== {1'b1, 12'h341}) begin n_fail++; $display("FAIL st_c17_ex_resume: got en=%b adr=%h want 1 341", csr_en, csr_adr); end
    n_cmp++; if (mon_rdata !== 32'h0000_1888) begin n_fail++; $display("FAIL st_c17_rdata: got %h want 00001888", mon_rdata); end
    next_cycle();
    ex_csr_req = 1'b0;
`else
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (csr_en && csr_adr == 12'h341) ex_grants++;
      if (ex_stall) stalls++;
      if (mon_ack) acks++;
      next_cycle();
    end
    n_cmp++; if (ex_grants !== 20) begin n_fail++; $display("FAIL st_ex_grants: got %0d want 20", ex_grants); end
    n_cmp++; if (stalls !== 0) begin n_fail++; $display("FAIL st_no_stall: got %0d want 0", stalls); end
    n_cmp++; if (acks !== 0) begin n_fail++; $display("FAIL st_no_ack: got %0d want 0", acks); end
    ex_csr_req = 1'b0;
    @(negedge clk);
    n_cmp++; if ({csr_en, csr_adr} !== {1'b1, 12'h300}) begin n_fail++; $display("FAIL st_late_grant: got en=%b adr=%h want 1 300", csr_en, csr_adr); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (mon_ack !== 1'b1) begin n_fail++; $display("FAIL st_late_ack: got %b want 1", mon_ack); end
    n_cmp++; if (mon_rdata !== 32'h0000_1888) begin n_fail++; $display("FAIL st_late_rdata: got %h want 00001888", mon_rdata); end
    next_cycle();
`endif
    @(negedge clk);
    n_cmp++; if (mon_busy !== 1'b0) begin n_fail++; $display("FAIL st_end_busy: got %b want 0", mon_busy); end
    next_cycle();
  endtask

  task automatic test_ignore_busy();
    int acks = 0;
    mon_req = 1'b1; mon_we = 1'b0; mon_adr = 12'h300; ex_csr_req = 1'b0;
    @(negedge clk);
    next_cycle();
    mon_adr = 12'h305;
    @(negedge clk);
    n_cmp++; if (csr_adr !== 12'h300) begin n_fail++; $display("FAIL ig_c1_adr: got %h want 300", csr_adr); end
    if (mon_ack) acks++;
    next_cycle();
    @(negedge clk);
    if (mon_ack) acks++;
    next_cycle();
    mon_req = 1'b0;
    for (int c = 3; c <= 8; c++) begin
      @(negedge clk);
      if (mon_ack) acks++;
      next_cycle();
    end
    n_cmp++; if (acks !== 1) begin n_fail++; $display("FAIL ig_ack_count: got %0d want 1", acks); end
    n_cmp++; if (mon_rdata !== 32'h0000_1888) begin n_fail++; $display("FAIL ig_rdata: got %h want 00001888", mon_rdata); end
  endtask

  task automatic test_reset_in_pend();
    mon_req = 1'b1; mon_we = 1'b1; mon_adr = 12'h305; mon_wdata = 32'h0000_0777;
    ex_csr_req = 1'b1; ex_csr_we = 1'b0; ex_csr_adr = 12'h342;
    @(negedge clk);
    next_cycle();
    mon_req = 1'b0;
    @(negedge clk);
    n_cmp++; if ({mon_busy, csr_adr} !== {1'b1, 12'h342}) begin n_fail++; $display("FAIL rp_pend: got busy=%b adr=%h want 1 342", mon_busy, csr_adr); end
    #2;
    rst_n = 1'b0;
    ex_csr_req = 1'b0;
    #1;
    n_cmp++; if ({mon_busy, csr_en, ex_stall} !== 3'b000) begin n_fail++; $display("FAIL rp_immediate: got busy/en/stall=%b want 000", {mon_busy, csr_en, ex_stall}); end
    next_cycle();
    n_cmp++; if ({mon_ack, csr_en, mon_rdata} !== {1'b0, 1'b0, 32'h0}) begin n_fail++; $display("FAIL rp_held: got ack=%b en=%b rdata=%h want 0 0 0", mon_ack, csr_en, mon_rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    mon_req = 1'b1; mon_we = 1'b0; mon_adr = 12'h300;
    @(negedge clk);
    next_cycle();
    mon_req = 1'b0;
    @(negedge clk);
    n_cmp++; if ({csr_en, csr_we, csr_adr} !== {1'b1, 1'b0, 12'h300}) begin n_fail++; $display("FAIL rp_after_grant: got en=%b we=%b adr=%h want 1 0 300", csr_en, csr_we, csr_adr); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if ({mon_ack, mon_rdata} !== {1'b1, 32'h0000_1888}) begin n_fail++; $display("FAIL rp_after_ack: got ack=%b rdata=%h want 1 00001888", mon_ack, mon_rdata); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_mon_read();
    test_mon_write_ex_pulse();
    test_starve();
    test_ignore_busy();
    test_reset_in_pend();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
